// File: rtl/rat_pkg.sv
// Shared types and constants for the rational arithmetic stages.
package rat_pkg;

  localparam int unsigned RAT_WIDTH         = 32;
  localparam int unsigned RAT_GCD_MAX_STEPS = 4 * RAT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    GCD,
    DIV_NUM,
    DIV_DEN,
    DONE
  } rat_reduce_state_t;

  typedef struct packed {
    logic [RAT_WIDTH-1:0] num;
    logic [RAT_WIDTH-1:0] den;
  } rat_frac_t;

endpackage

// File: rtl/rat_udiv.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles per divide
// counting the start cycle, done pulses for one cycle once quotient/remainder are final.
module rat_udiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_src, q_src, d_src, r_nxt, q_nxt;
  logic [WIDTH:0]   shifted, diff;

  // The start cycle already performs the first iteration on the fresh operands.
  always_comb begin
    r_src   = start ? '0 : rem_q;
    q_src   = start ? dividend : quo_q;
    d_src   = start ? divisor : dvs_q;
    shifted = {r_src, q_src[WIDTH-1]};
    diff    = shifted - {1'b0, d_src};
    if (diff[WIDTH]) begin
      r_nxt = shifted[WIDTH-1:0];
      q_nxt = {q_src[WIDTH-2:0], 1'b0};
    end else begin
      r_nxt = diff[WIDTH-1:0];
      q_nxt = {q_src[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= r_nxt;
        quo_q <= q_nxt;
        dvs_q <= divisor;
        cnt_q <= CW'(WIDTH - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= r_nxt;
        quo_q <= q_nxt;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/rat_reduce.sv
// Reduces a signed fraction to lowest terms: binary GCD, then two exact divisions by
// the GCD on a shared divider. Valid/ready on both sides, one fraction in flight.
module rat_reduce
  import rat_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_err
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;

  rat_reduce_state_t state, state_nxt;

  logic             sign_q;
  logic [WIDTH-1:0] mag_q, den_q, a_q, b_q, g_q, qn_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] gcd_now;

  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem;

  assign gcd_now = b_q << k_q;

  rat_udiv #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The numerator divide is launched on the final GCD cycle, so DIV_NUM and DIV_DEN
  // each last exactly WIDTH cycles and the divider is never idle between them.
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = mag_q;
    div_divisor  = gcd_now;
    case (state)
      IDLE:    if (in_valid) state_nxt = CHECK;
      CHECK:   state_nxt = (den_q == '0 || mag_q == '0) ? DONE : GCD;
      GCD:
        if (a_q == '0) begin
          div_start = 1'b1;
          state_nxt = DIV_NUM;
        end
      DIV_NUM:
        if (div_done) begin
          div_start    = 1'b1;
          div_dividend = den_q;
          div_divisor  = g_q;
          state_nxt    = DIV_DEN;
        end
      DIV_DEN: if (div_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      den_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      k_q     <= '0;
      qn_q    <= '0;
      out_num <= '0;
      out_den <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            sign_q <= in_num[WIDTH-1];
            mag_q  <= in_num[WIDTH-1] ? -in_num : in_num;
            den_q  <= in_den;
          end
        CHECK:
          if (den_q == '0) begin
            out_num <= sign_q ? -mag_q : mag_q;
            out_den <= '0;
            out_err <= 1'b1;
          end else if (mag_q == '0) begin
            out_num <= '0;
            out_den <= WIDTH'(1);
            out_err <= 1'b0;
          end else begin
            a_q <= mag_q;
            b_q <= den_q;
            k_q <= '0;
          end
        GCD:
          if (a_q == '0) begin
            g_q <= gcd_now;
          end else if (!a_q[0] && !b_q[0]) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KW'(1);
          end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (!b_q[0]) begin
            b_q <= b_q >> 1;
          end else if (a_q >= b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        DIV_NUM: if (div_done) qn_q <= div_quo;
        DIV_DEN:
          if (div_done) begin
            out_num <= sign_q ? -qn_q : qn_q;
            out_den <= div_quo;
            out_err <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (div_done && (state == DIV_NUM || state == DIV_DEN)) |-> (div_rem == '0));

  assert property (@(posedge clk) disable iff (rst) div_start |-> !div_busy);

endmodule

// File: tb/tb_rat_reduce.sv
// Directed table plus handshake/reset sequences and a random sweep against a
// Euclid-based reference for rat_reduce.
module tb_rat_reduce;
  import rat_pkg::*;

  localparam int unsigned W       = 32;
  localparam int          LAT_MAX = 2 * W + RAT_GCD_MAX_STEPS + 3;
  localparam int unsigned BOUND   = 1 << 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_err;
  logic [W-1:0] in_num, in_den, out_num, out_den;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rat_reduce #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_den   (out_den),
    .out_err   (out_err)
  );

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] exp_num;
    logic [W-1:0] exp_den;
    logic         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic send(input logic [W-1:0] n, input logic [W-1:0] d);
    in_num   = n;
    in_den   = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat = rising edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat <= LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid arrives in bound", {95'd0, out_valid}, 96'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle after accept", {94'd0, out_valid, in_ready}, {94'd0, 1'b0, 1'b1});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           lat;
    int           seen;
    logic [W-1:0] mag, d, g, qn, n, en, ed;
    logic         neg, ee;

    rst = 1'b1; in_valid = 1'b0; in_num = '0; in_den = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {29'd0, in_ready, out_valid, out_err, out_num, out_den},
        {29'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{32'd12,         32'd18,         32'd2,          32'd3, 1'b0});
    vecs.push_back('{32'd255,        32'd1,          32'd255,        32'd1, 1'b0});
    vecs.push_back('{32'd7,          32'd7,          32'd1,          32'd1, 1'b0});
    vecs.push_back('{32'hFFFFFFFA,   32'd4,          32'hFFFFFFFD,   32'd2, 1'b0});
    vecs.push_back('{32'hFFFFFC00,   32'd4096,       32'hFFFFFFFF,   32'd4, 1'b0});
    vecs.push_back('{32'd0,          32'd7,          32'd0,          32'd1, 1'b0});
    vecs.push_back('{32'd5,          32'd0,          32'd5,          32'd0, 1'b1});
    vecs.push_back('{32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   32'd0, 1'b1});
    vecs.push_back('{32'd0,          32'd0,          32'd0,          32'd0, 1'b1});
    vecs.push_back('{32'h80000000,   32'd2,          32'hC0000000,   32'd1, 1'b0});
    vecs.push_back('{32'h80000000,   32'h80000000,   32'hFFFFFFFF,   32'd1, 1'b0});
    vecs.push_back('{32'd9,          32'd27,         32'd1,          32'd3, 1'b0});
    vecs.push_back('{32'd1,          32'hFFFFFFFF,   32'd1,   32'hFFFFFFFF, 1'b0});

    foreach (vecs[i]) begin
      send(vecs[i].num, vecs[i].den);
      wait_valid(lat);
      chk($sformatf("vec%0d result", i), {31'd0, out_err, out_num, out_den},
          {31'd0, vecs[i].exp_err, vecs[i].exp_num, vecs[i].exp_den});
      if (vecs[i].num == '0 || vecs[i].den == '0)
        chk($sformatf("vec%0d short latency", i), 96'(lat), 96'd2);
      release_out();
    end

    // Back-pressure: result must hold while the consumer stalls.
    send(32'd12, 32'd18);
    wait_valid(lat);
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall hold", {29'd0, out_valid, in_ready, out_err, out_num, out_den},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd3});
    end
    release_out();

    // Abort in the middle of the GCD loop.
    send(32'd1000, 32'd750);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("reset mid-gcd", {29'd0, in_ready, out_valid, out_err, out_num, out_den},
        {29'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no result after abort", 96'(seen), 96'd0);
    send(32'd9, 32'd27);
    wait_valid(lat);
    chk("after abort 9/27", {31'd0, out_err, out_num, out_den}, {31'd0, 1'b0, 32'd1, 32'd3});
    release_out();

    repeat (400) begin
      mag = W'($urandom_range(0, BOUND - 1));
      d   = W'($urandom_range(0, BOUND - 1));
      neg = 1'($urandom_range(0, 1));
      n   = neg ? -mag : mag;
      if (d == '0) begin
        en = n; ed = '0; ee = 1'b1;
      end else if (mag == '0) begin
        en = '0; ed = 1; ee = 1'b0;
      end else begin
        g  = gcd_ref(mag, d);
        qn = mag / g;
        en = neg ? -qn : qn;
        ed = d / g;
        ee = 1'b0;
      end
      send(n, d);
      wait_valid(lat);
      chk($sformatf("rand %h/%h", n, d), {31'd0, out_err, out_num, out_den}, {31'd0, ee, en, ed});
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
